conv_frame_sched: RTL

Frame scheduler that shares one `convenc` convolutional encoder between two bit-serial requesters. It arbitrates round-robin, loads the granted requester's seed into the encoder, and streams that requester's payload bits with `valid_in` framing. It then appends zero tail bits to terminate the trellis and reports completion. It sits between the framing layer and `convenc`, and drives the encoder's `load`, `seed`, `data` and `valid_in` inputs.

---
 rtl/conv_frame_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/conv_frame_sched.sv
// Round-robin frame scheduler feeding one shared convolutional encoder from two bit-serial sources.
// Define CONV_SCHED_TAIL_EN to append TAIL_BITS zero bits per frame for trellis termination.
module conv_frame_sched #(
    parameter int LEN_W     = 8,
    parameter int SEED_W    = 3,
    parameter int TAIL_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [SEED_W-1:0] seed0,
    input  logic [SEED_W-1:0] seed1,
    input  logic              data0,
    input  logic              data1,
    input  logic              hold,
    output logic              take0,
    output logic              take1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              enc_load,
    output logic [SEED_W-1:0] enc_seed,
    output logic              enc_data,
    output logic              enc_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              src_id
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DATA,
        ST_DONE
`ifdef CONV_SCHED_TAIL_EN
        , ST_TAIL
`endif
    } state_t;

`ifdef CONV_SCHED_TAIL_EN
    localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(TAIL_BITS);
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic               src_id_q, src_id_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               enc_load_q, enc_load_d;
    logic [SEED_W-1:0]  enc_seed_q, enc_seed_d;
    logic               enc_data_q, enc_data_d;
    logic               enc_valid_q, enc_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               pick;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_d       = prio_q;
        src_id_d     = src_id_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        enc_load_d   = 1'b0;
        enc_seed_d   = enc_seed_q;
        enc_data_d   = enc_data_q;
        enc_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        pick         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // prio_q names the source that wins a tie: the one not served last
                    pick       = (req0 && req1) ? prio_q : req1;
                    src_id_d   = pick;
                    gnt0_d     = ~pick;
                    gnt1_d     = pick;
                    cnt_d      = pick ? len1 : len0;
                    enc_seed_d = pick ? seed1 : seed0;
                    enc_load_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q != '0) begin
                    state_d = ST_DATA;
                end else begin
`ifdef CONV_SCHED_TAIL_EN
                    state_d = ST_TAIL;
                    cnt_d   = TAIL_LEN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DATA: begin
                if (!hold) begin
                    enc_data_d  = src_id_q ? data1 : data0;
                    enc_valid_d = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
`ifdef CONV_SCHED_TAIL_EN
                        state_d = ST_TAIL;
                        cnt_d   = TAIL_LEN;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef CONV_SCHED_TAIL_EN
            ST_TAIL: begin
                if (!hold) begin
                    enc_data_d  = 1'b0;
                    enc_valid_d = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                gnt0_d       = 1'b0;
                gnt1_d       = 1'b0;
                frame_done_d = 1'b1;
                prio_d       = ~src_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prio_q       <= 1'b0;
            src_id_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            enc_load_q   <= 1'b0;
            enc_seed_q   <= '0;
            enc_data_q   <= 1'b0;
            enc_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_q       <= prio_d;
            src_id_q     <= src_id_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            enc_load_q   <= enc_load_d;
            enc_seed_q   <= enc_seed_d;
            enc_data_q   <= enc_data_d;
            enc_valid_q  <= enc_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // take is gated by reset so a source never advances on an edge that aborts the frame
    assign take0      = reset && (state_q == ST_DATA) && !hold && !src_id_q;
    assign take1      = reset && (state_q == ST_DATA) && !hold &&  src_id_q;
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign enc_load   = enc_load_q;
    assign enc_seed   = enc_seed_q;
    assign enc_data   = enc_data_q;
    assign enc_valid  = enc_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign src_id     = src_id_q;

endmodule
